// File: rtl/pc_redirect_ctrl_pkg.sv
// ============================================================================
// Module : pc_redirect_ctrl_pkg
// Brief  : Shared state encodings and address defaults for the next-PC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FLUSH = 2'b11
  } pc_state_t;

  localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] C_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] C_IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] C_IMEM_HI    = 32'h0000_6ffc;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_addr_check.sv
// ============================================================================
// Module : pc_addr_check
// Brief  : Flags a fetch address that is misaligned or outside instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_addr_check #(
  parameter logic [31:0] IMEM_LO = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI = 32'h0000_6ffc
) (
  input  logic        en,
  input  logic [31:0] pc,
  output logic        bad
);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned   = (pc[1:0] != 2'b00);
  assign w_out_of_range = (pc < IMEM_LO) || (pc > IMEM_HI);
  assign bad            = en && (w_misaligned || w_out_of_range);

endmodule

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module : pc_redirect_ctrl
// Brief  : Next-PC sequencer: exception / eret / branch / PC+4 arbitration with
//          stall-time redirect buffering and F/D flush generation.
//          Optional fetch-address check enabled by macro PC_ALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = C_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = C_EXC_VECTOR,
  parameter logic [31:0] IMEM_LO    = C_IMEM_LO,
  parameter logic [31:0] IMEM_HI    = C_IMEM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic        flush_fd,
  output logic        adel
);

  pc_state_t   state_q, state_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pend_eret_q, pend_eret_d;
  logic        flush_fd_q;
  logic [31:0] w_eret_target;

  assign w_eret_target = word_align(epc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pend_addr_q <= 32'h0;
      pend_eret_q <= 1'b0;
      flush_fd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_eret_q <= pend_eret_d;
      flush_fd_q  <= (state_d == ST_FLUSH);
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_eret_d = pend_eret_q;
    pc_next     = pc_cur;
    pc_we       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_next = RESET_PC;
        pc_we   = 1'b1;
        state_d = ST_RUN;
      end

      ST_HOLD: begin
        if (exc_req) begin
          pc_next     = EXC_VECTOR;
          pc_we       = 1'b1;
          pend_addr_d = 32'h0;
          pend_eret_d = 1'b0;
          state_d     = ST_FLUSH;
        end else if (!stall) begin
          // First buffered redirect wins; anything decoded during the hold is dropped.
          pc_next     = pend_addr_q;
          pc_we       = 1'b1;
          pend_addr_d = 32'h0;
          pend_eret_d = 1'b0;
          state_d     = pend_eret_q ? ST_FLUSH : ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
        if (exc_req) begin
          pc_next = EXC_VECTOR;
          pc_we   = 1'b1;
          state_d = ST_FLUSH;
        end else if (eret && !stall) begin
          pc_next = w_eret_target;
          pc_we   = 1'b1;
          state_d = ST_FLUSH;
        end else if (br_valid && !stall) begin
          pc_next = br_target;
          pc_we   = 1'b1;
        end else if (stall && (eret || br_valid)) begin
          pend_addr_d = eret ? w_eret_target : br_target;
          pend_eret_d = eret;
          state_d     = ST_HOLD;
        end else if (!stall) begin
          pc_next = pc_cur + 32'd4;
          pc_we   = 1'b1;
        end
      end
    endcase
  end

  assign flush_fd = flush_fd_q;

`ifdef PC_ALIGN_CHECK_EN
  pc_addr_check #(
    .IMEM_LO (IMEM_LO),
    .IMEM_HI (IMEM_HI)
  ) u_addr_check (
    .en  (state_q != ST_BOOT),
    .pc  (pc_cur),
    .bad (adel)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{IMEM_LO, IMEM_HI};
  assign adel         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ============================================================================
// Module : tb_pc_redirect_ctrl
// Brief  : Directed and randomized checks of pc_redirect_ctrl against a
//          behavioural next-PC model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_ctrl;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] pc_cur = 32'h0000_3002;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        flush_fd;
  logic        adel;

  int total = 0;
  int bad   = 0;

  pc_redirect_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .br_valid  (br_valid),
    .br_target (br_target),
    .pc_cur    (pc_cur),
    .pc_next   (pc_next),
    .pc_we     (pc_we),
    .flush_fd  (flush_fd),
    .adel      (adel)
  );

  always #5 clk = ~clk;

  // Behavioural model: booting flag, one-deep pending redirect, flush owed.
  bit          m_boot = 1'b1;
  bit          m_pend = 1'b0;
  bit          m_peret = 1'b0;
  bit          m_flush = 1'b0;
  logic [31:0] m_paddr = 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_boot  = 1'b1;
      m_pend  = 1'b0;
      m_peret = 1'b0;
      m_flush = 1'b0;
    end else if (m_boot) begin
      m_boot  = 1'b0;
      m_flush = 1'b0;
    end else begin
      bit commit_flush;
      commit_flush = exc_req || (!m_pend && eret && !stall) ||
                     (m_pend && !stall && m_peret);
      if (exc_req) begin
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (!stall) m_pend = 1'b0;
      end else if (stall && (eret || br_valid)) begin
        m_pend  = 1'b1;
        m_peret = eret;
        m_paddr = eret ? (epc & 32'hffff_fffc) : br_target;
      end
      m_flush = commit_flush;
    end
  end

  logic [31:0] e_pc;
  logic        e_we, e_fl, e_ad;

  always @(negedge clk) begin
    e_fl = m_flush && reset;
    e_ad = ALIGN_ON && reset && !m_boot &&
           ((pc_cur % 4) != 0 || pc_cur < 32'h3000 || pc_cur > 32'h6ffc);
    if (!reset || m_boot)           begin e_pc = 32'h3000;                 e_we = 1'b1; end
    else if (exc_req)               begin e_pc = 32'h4180;                 e_we = 1'b1; end
    else if (m_pend)                begin e_pc = m_paddr;                  e_we = !stall; end
    else if (stall)                 begin e_pc = pc_cur;                   e_we = 1'b0; end
    else if (eret)                  begin e_pc = epc & 32'hffff_fffc;      e_we = 1'b1; end
    else if (br_valid)              begin e_pc = br_target;                e_we = 1'b1; end
    else                            begin e_pc = pc_cur + 32'd4;           e_we = 1'b1; end

    total++;
    if (pc_we !== e_we) begin
      bad++;
      $display("FAIL model_pc_we t=%0t got=%b exp=%b", $time, pc_we, e_we);
    end
    if (e_we) begin
      total++;
      if (pc_next !== e_pc) begin
        bad++;
        $display("FAIL model_pc_next t=%0t got=%h exp=%h", $time, pc_next, e_pc);
      end
    end
    total++;
    if (flush_fd !== e_fl) begin
      bad++;
      $display("FAIL model_flush_fd t=%0t got=%b exp=%b", $time, flush_fd, e_fl);
    end
    total++;
    if (adel !== e_ad) begin
      bad++;
      $display("FAIL model_adel t=%0t got=%b exp=%b pc=%h", $time, adel, e_ad, pc_cur);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit ex, input bit er, input logic [31:0] ep,
                      input bit bv, input logic [31:0] bt, input logic [31:0] pc);
    @(posedge clk);
    #1;
    stall = st; exc_req = ex; eret = er; epc = ep;
    br_valid = bv; br_target = bt; pc_cur = pc;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 32'h0000_3000;
      1: return 32'h0000_2ffc;
      2: return 32'h0000_6ffc;
      3: return 32'h0000_7000;
      4: return 32'hffff_fffc;
      5: return $urandom;
      default: return 32'h0000_3000 + ($urandom_range(0, 32'h0fff) << 2);
    endcase
  endfunction

  initial begin
    // Reset and boot
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_next", pc_next, 32'h3000);
    chk("rst_pc_we", {31'b0, pc_we}, 32'h1);
    chk("rst_flush", {31'b0, flush_fd}, 32'h0);
    chk("rst_adel", {31'b0, adel}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("boot_pc_next", pc_next, 32'h3000);
    chk("boot_pc_we", {31'b0, pc_we}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h3000);
    chk("seq_pc_next", pc_next, 32'h3004);
    chk("seq_pc_we", {31'b0, pc_we}, 32'h1);

    // Branch buffered over a 3-cycle stall
    step(1, 0, 0, 32'h0, 1, 32'h3100, 32'h3004);
    chk("hold1_we", {31'b0, pc_we}, 32'h0);
    step(1, 0, 0, 32'h0, 1, 32'h3100, 32'h3004);
    chk("hold2_we", {31'b0, pc_we}, 32'h0);
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h3004);
    chk("hold3_we", {31'b0, pc_we}, 32'h0);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h3004);
    chk("release_pc_next", pc_next, 32'h3100);
    chk("release_we", {31'b0, pc_we}, 32'h1);
    chk("release_flush", {31'b0, flush_fd}, 32'h0);

    // Exception beats eret and stall
    step(1, 1, 1, 32'h3203, 0, 32'h0, 32'h3100);
    chk("exc_pc_next", pc_next, 32'h4180);
    chk("exc_we", {31'b0, pc_we}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h4180);
    chk("exc_flush", {31'b0, flush_fd}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h4184);
    chk("exc_flush_end", {31'b0, flush_fd}, 32'h0);

    // eret with unaligned EPC
    step(0, 0, 1, 32'h3203, 0, 32'h0, 32'h4188);
    chk("eret_pc_next", pc_next, 32'h3200);
    chk("eret_we", {31'b0, pc_we}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h3200);
    chk("eret_flush", {31'b0, flush_fd}, 32'h1);

    // Exception during HOLD drops the pending branch
    step(1, 0, 0, 32'h0, 1, 32'h3100, 32'h3204);
    chk("hold_exc_we0", {31'b0, pc_we}, 32'h0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 32'h3204);
    chk("hold_exc_pc", pc_next, 32'h4180);
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h4180);
    chk("hold_exc_flush", {31'b0, flush_fd}, 32'h1);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'h4180);
    chk("hold_exc_dropped", pc_next, 32'h4184);

    // Fetch address check
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h3002);
    chk("adel_3002", {31'b0, adel}, {31'b0, ALIGN_ON});
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h7000);
    chk("adel_7000", {31'b0, adel}, {31'b0, ALIGN_ON});
    step(1, 0, 0, 32'h0, 0, 32'h0, 32'h6ffc);
    chk("adel_6ffc", {31'b0, adel}, 32'h0);
    step(0, 0, 0, 32'h0, 0, 32'h0, 32'hffff_fffc);
    chk("wrap_pc_next", pc_next, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 299) != 0);
      stall     = ($urandom_range(0, 2) == 0);
      exc_req   = ($urandom_range(0, 15) == 0);
      eret      = ($urandom_range(0, 7) == 0);
      br_valid  = ($urandom_range(0, 3) == 0);
      epc       = rand_pc() | 32'($urandom_range(0, 3));
      br_target = rand_pc();
      pc_cur    = rand_pc();
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
